// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//   Byte-addressable 32-bit data memory controller. After reset it optionally
//   zeroes every word with a one-word-per-cycle sweep, then serves one
//   load/store request per cycle with a fixed one-cycle response.
//
// Parameters
//   ADDR_W          byte-address width; depth = 2^(ADDR_W-2) words
//   CLEAR_ON_RESET  1 = zero all words by sequential sweep after reset release
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous, active-high reset
//   req_valid     request present
//   req_ready     controller can accept a request (IDLE)
//   req_we        1 = store, 0 = load
//   req_addr      byte address
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads zero-extend when 1, sign-extend when 0
//   req_wdata     store data, right-aligned
//   rsp_valid     one-cycle response pulse, one cycle after acceptance
//   rsp_rdata     load result, extended to 32 bits (0 for stores/errors)
//   rsp_err       request was misaligned or illegal
//   busy          clear sweep in progress
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int ADDR_W         = 7,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int WIDX_W = ADDR_W - 2;
  localparam int DEPTH  = 1 << WIDX_W;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [0:0]        r_state;
  logic [WIDX_W-1:0] r_clr_cnt;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_accept;
  logic [WIDX_W-1:0] w_idx;
  logic [1:0]        w_off;
  logic              w_err;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_shifted;
  logic [31:0]       w_load_data;
  logic [3:0]        w_store_be;
  logic [31:0]       w_store_data;
  logic [3:0]        w_mem_we;
  logic [WIDX_W-1:0] w_mem_idx;
  logic [31:0]       w_mem_wdata;

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_CLEAR);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_idx    = req_addr[ADDR_W-1:2];
  assign w_off    = req_addr[1:0];

  // Alignment / legality check.
  always_comb begin
    w_err = 1'b0;
    case (req_size)
      SZ_BYTE: w_err = 1'b0;
      SZ_HALF: w_err = req_addr[0];
      SZ_WORD: w_err = |req_addr[1:0];
      default: w_err = 1'b1;
    endcase
  end

  // Store lanes: data is replicated across lanes so each byte lane only has
  // to pick its own slice; the byte enables select which lanes actually write.
  always_comb begin
    w_store_be   = 4'b1111;
    w_store_data = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        w_store_be   = 4'b0001 << w_off;
        w_store_data = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_store_be   = 4'b0011 << w_off;
        w_store_data = {2{req_wdata[15:0]}};
      end
      default: begin
        w_store_be   = 4'b1111;
        w_store_data = req_wdata;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  assign w_shifted = w_rd_word >> {w_off, 3'b000};

  always_comb begin
    w_load_data = w_rd_word;
    case (req_size)
      SZ_BYTE: w_load_data = req_unsigned ? {24'h0, w_shifted[7:0]}
                                          : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: w_load_data = req_unsigned ? {16'h0, w_shifted[15:0]}
                                          : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_data = w_rd_word;
    endcase
  end

  // Single memory write port shared by the clear sweep and stores.
  always_comb begin
    w_mem_we    = 4'b0000;
    w_mem_idx   = w_idx;
    w_mem_wdata = w_store_data;
    if (r_state == S_CLEAR) begin
      if (CLEAR_ON_RESET) begin
        w_mem_we    = 4'b1111;
        w_mem_idx   = r_clr_cnt;
        w_mem_wdata = 32'h0;
      end
    end else if (w_accept && req_we && !w_err) begin
      w_mem_we = w_store_be;
    end
  end

  // One byte-wide array per lane. The read is asynchronous so a load issued
  // right after a store to the same word sees the merged data; the result is
  // registered in the response stage. Writes are held off while rst is high
  // because the array itself is never reset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst && w_mem_we[gi]) begin
          r_mem[w_mem_idx] <= w_mem_wdata[8*gi +: 8];
        end
      end

      assign w_rd_word[8*gi +: 8] = r_mem[w_idx];
    end
  endgenerate

  // FSM, sweep counter and response stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_clr_cnt   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_err   <= w_accept && w_err;
      r_rsp_rdata <= (w_accept && !req_we && !w_err) ? w_load_data : 32'h0;

      case (r_state)
        S_CLEAR: begin
          if (!CLEAR_ON_RESET) begin
            r_state <= S_IDLE;
          end else begin
            r_clr_cnt <= r_clr_cnt + WIDX_W'(1);
            // Leave after clearing the last word; the counter wraps to 0.
            if (&r_clr_cnt) begin
              r_state <= S_IDLE;
            end
          end
        end
        S_IDLE:  r_state <= S_IDLE;
        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 32;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [6:0]  req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  dmem_ctrl #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] model_mem [DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every response must match the oldest expectation, arrive in
  // the cycle it was due, and no response may appear without one.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h at cycle %0d, required no response", rsp_rdata, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cyc !== mon_e.due || rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err) begin
          errors++;
          $display("FAIL %s: got cycle=%0d rdata=%h err=%b, required cycle=%0d rdata=%h err=%b",
                   mon_e.name, cyc, rsp_rdata, rsp_err, mon_e.due, mon_e.rdata, mon_e.err);
        end else begin
          $display("ok   %s: cycle=%0d rdata=%h err=%b", mon_e.name, cyc, rsp_rdata, rsp_err);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      checks++;
      errors++;
      mon_e = sb.pop_front();
      $display("FAIL %s_missing: rsp_valid=0 at cycle %0d, required 1", mon_e.name, cyc);
    end
  end

  task automatic issue(input string name, input logic we, input logic [6:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    e.due   = cyc + 1;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.name  = name;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    idle(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d responses outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Reference behaviour of one request against the bench's own memory copy.
  function automatic void model_access(input logic we, input logic [6:0] a, input logic [1:0] sz,
                                       input logic uns, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er);
    logic [31:0] w;
    int          o;
    o  = int'(a[1:0]);
    w  = model_mem[a[6:2]];
    rd = 32'h0;
    er = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    if (!er) begin
      if (we) begin
        if (sz == 2'b00)      w[8*o +: 8]  = wd[7:0];
        else if (sz == 2'b01) w[8*o +: 16] = wd[15:0];
        else                  w = wd;
        model_mem[a[6:2]] = w;
      end else begin
        if (sz == 2'b00)
          rd = uns ? {24'h0, w[8*o +: 8]} : {{24{w[8*o+7]}}, w[8*o +: 8]};
        else if (sz == 2'b01)
          rd = uns ? {16'h0, w[8*o +: 16]} : {{16{w[8*o+15]}}, w[8*o +: 16]};
        else
          rd = w;
      end
    end
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0 ||
        rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b busy=%b valid=%b rdata=%h err=%b, required 0 1 0 00000000 0",
               req_ready, busy, rsp_valid, rsp_rdata, rsp_err);
    end
  endtask

  // Release reset with a store to word 0 held on the bus: it must be ignored
  // for the whole sweep and ready must rise only after the 32nd edge.
  task automatic test_sweep();
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_addr     = 7'h00;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_wdata    = 32'hFFFF_FFFF;
    rst          = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sweep_start: ready=%b busy=%b, required 0 1", req_ready, busy);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (i < DEPTH) begin
        if (req_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL sweep_edge%0d: ready=%b busy=%b valid=%b, required 0 1 0", i, req_ready, busy, rsp_valid);
        end
      end else begin
        if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL sweep_done: ready=%b busy=%b valid=%b, required 1 0 0", req_ready, busy, rsp_valid);
        end
      end
    end
    req_valid = 1'b0;
    $display("sweep: ready after %0d edges", DEPTH);
  endtask

  task automatic test_sign_ext();
    issue("st_w_04",    1'b1, 7'h04, 2'b10, 1'b0, 32'h8000_00F5, 32'h0000_0000, 1'b0);
    issue("ld_b_04_s",  1'b0, 7'h04, 2'b00, 1'b0, 32'h0,         32'hFFFF_FFF5, 1'b0);
    issue("ld_b_04_u",  1'b0, 7'h04, 2'b00, 1'b1, 32'h0,         32'h0000_00F5, 1'b0);
    issue("ld_b_07_s",  1'b0, 7'h07, 2'b00, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0);
    drain("sign_ext");
  endtask

  task automatic test_merge();
    issue("st_w_08",    1'b1, 7'h08, 2'b10, 1'b0, 32'h1122_3344, 32'h0000_0000, 1'b0);
    issue("st_h_0a",    1'b1, 7'h0A, 2'b01, 1'b0, 32'h5555_BEEF, 32'h0000_0000, 1'b0);
    issue("ld_w_08",    1'b0, 7'h08, 2'b10, 1'b1, 32'h0,         32'hBEEF_3344, 1'b0);
    issue("ld_h_0a_s",  1'b0, 7'h0A, 2'b01, 1'b0, 32'h0,         32'hFFFF_BEEF, 1'b0);
    issue("ld_h_0a_u",  1'b0, 7'h0A, 2'b01, 1'b1, 32'h0,         32'h0000_BEEF, 1'b0);
    issue("ld_b_09_u",  1'b0, 7'h09, 2'b00, 1'b1, 32'h0,         32'h0000_0033, 1'b0);
    drain("merge");
  endtask

  task automatic test_misaligned();
    issue("ld_w_06_err", 1'b0, 7'h06, 2'b10, 1'b0, 32'h0,         32'h0, 1'b1);
    issue("st_h_03_err", 1'b1, 7'h03, 2'b01, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1);
    issue("sz11_00_err", 1'b1, 7'h00, 2'b11, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b1);
    issue("ld_w_04_keep", 1'b0, 7'h04, 2'b10, 1'b0, 32'h0, 32'h8000_00F5, 1'b0);
    issue("ld_w_00_zero", 1'b0, 7'h00, 2'b10, 1'b0, 32'h0, 32'h0000_0000, 1'b0);
    drain("misaligned");
  endtask

  task automatic test_back_to_back();
    issue("b2b_st_w_10", 1'b1, 7'h10, 2'b10, 1'b0, 32'hAABB_CCDD, 32'h0,          1'b0);
    issue("b2b_st_b_12", 1'b1, 7'h12, 2'b00, 1'b0, 32'h0000_0011, 32'h0,          1'b0);
    issue("b2b_ld_w_10", 1'b0, 7'h10, 2'b10, 1'b0, 32'h0,         32'hAA11_CCDD, 1'b0);
    issue("b2b_ld_h_12", 1'b0, 7'h12, 2'b01, 1'b1, 32'h0,         32'h0000_AA11, 1'b0);
    drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    issue("rm_st_04", 1'b1, 7'h04, 2'b10, 1'b0, 32'h0000_0005, 32'h0, 1'b0);
    issue("rm_st_08", 1'b1, 7'h08, 2'b10, 1'b0, 32'h0000_0005, 32'h0, 1'b0);
    // A load whose response is killed by reset right after acceptance.
    @(negedge clk);
    req_we   = 1'b0;
    req_addr = 7'h04;
    req_size = 2'b10;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop_rsp: valid=%b rdata=%h busy=%b ready=%b, required 0 00000000 1 0",
               rsp_valid, rsp_rdata, busy, req_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_sweep: valid=%b busy=%b ready=%b, required 0 1 0", rsp_valid, busy, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    // The restarted sweep must take the full depth again.
    repeat (DEPTH - 1) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_edge31: ready=%b, required 0", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_edge32: ready=%b, required 1", req_ready);
    end
    issue("rm_ld_04", 1'b0, 7'h04, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
    issue("rm_ld_08", 1'b0, 7'h08, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
    drain("reset_mid");
  endtask

  task automatic test_random();
    logic        we;
    logic [6:0]  a;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    sb.delete();
    for (int k = 0; k < DEPTH; k++) model_mem[k] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (DEPTH) @(posedge clk);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        we  = 1'($urandom_range(0, 1));
        a   = 7'($urandom_range(0, 23));
        sz  = 2'($urandom_range(0, 3));
        uns = 1'($urandom_range(0, 1));
        wd  = $urandom;
        model_access(we, a, sz, uns, wd, rd, er);
        issue(we ? "rnd_st" : "rnd_ld", we, a, sz, uns, wd, rd, er);
      end
    end
    drain("random");
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 7'h00;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;
    test_reset();
    test_sweep();
    test_sign_ext();
    test_merge();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, byte-address width; depth = 2^(ADDR_W-2) 32-bit words (default 32 words).
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1, 1 = zero all words by sequential sweep after reset release.
REQ-003 SHALL have ports, one per line:
 clk  input  1  sole clock, rising edge
 rst  input  1  asynchronous, active-high reset
 req_valid  input  1  request present
 req_ready  output  1  controller can accept a request
 req_we  input  1  1 = store, 0 = load
 req_addr  input  ADDR_W  byte address
 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
 req_wdata  input  32  store data, right-aligned (lane 0 holds byte/half)
 rsp_valid  output  1  one-cycle response pulse
 rsp_rdata  output  32  load result, extended to 32 bits
 rsp_err  output  1  request was misaligned/illegal
 busy  output  1  clear sweep in progress
REQ-004 One clock; reset is asynchronous and active-high, ports named clk and rst.

Function
REQ-005 SHALL implement a two-state FSM: CLEAR, IDLE.
REQ-006 CLEAR: each rising edge writes 0 to word clr_cnt, then increments clr_cnt; after the edge that clears word depth-1, next state = IDLE.
REQ-007 CLEAR SHALL last exactly depth edges after rst deassertion (32 by default); busy=1, req_ready=0 throughout.
REQ-008 With CLEAR_ON_RESET=0, the FSM SHALL enter IDLE on the first edge after release; memory contents are left untouched.
REQ-009 IDLE: req_ready=1 continuously, busy=0; one request accepted per edge where req_valid && req_ready.
REQ-010 Every accepted request SHALL produce exactly one response: rsp_valid=1 for exactly the following cycle, with registered rsp_rdata/rsp_err; latency is fixed at 1 cycle, with no response backpressure.
REQ-011 Back-to-back requests SHALL yield back-to-back rsp_valid pulses; rsp_valid=0 in any cycle not following an acceptance.
REQ-012 Word index = req_addr[ADDR_W-1:2]; lane offset = req_addr[1:0].
REQ-013 Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size=11. The response SHALL have rsp_err=1, rsp_rdata=0, and memory unchanged.
REQ-014 Store: merge only the addressed lanes (byte: 1 lane, half: lanes off..off+1, word: all); other bytes preserved; rsp_rdata=0, rsp_err=0.
REQ-015 Load byte/half: extract lane(s) at offset, then zero- or sign-extend per req_unsigned; word loads ignore req_unsigned.
REQ-016 Store then load of the same word on consecutive edges: the load SHALL return the stored (merged) data.
REQ-017 Requests presented while req_ready=0 SHALL be ignored: no response and no memory change.

Reset
REQ-018 While rst=1, asynchronously: state=CLEAR, clr_cnt=0, req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-019 Memory array SHALL NOT be cleared asynchronously; zeroing happens only via the CLEAR sweep.
REQ-020 rst asserted mid-sweep or mid-request: the in-flight response is dropped, and the sweep restarts from word 0 after release.

Verification
REQ-021 Release rst, hold req_valid=1 -> req_ready=0 and busy=1 for 32 cycles, req_ready=1 on cycle 33, and no response during the sweep.
REQ-022 Store word 0x8000_00F5 @0x04, then load byte @0x04 signed -> rsp_rdata=0xFFFF_FFF5; unsigned -> 0x0000_00F5.
REQ-023 Store word 0x1122_3344 @0x08, store half 0xBEEF @0x0A, load word @0x08 -> 0xBEEF_3344, load half @0x0A signed -> 0xFFFF_BEEF.
REQ-024 Load word @0x06, store half @0x03, size=11 @0x00 -> three responses with rsp_err=1 and rsp_rdata=0; a following load word @0x04 is unchanged.
REQ-025 Store 0x5 @0x04 and 0x5 @0x08, assert rst mid-sweep after release, then read both -> 0x0 after the sweep completes; rsp_valid=0 during reset.
REQ-026 Four back-to-back requests (two stores, two loads, same word) -> four consecutive rsp_valid pulses, each one cycle after acceptance, with loads returning the latest merged data.
